// File: rtl/sc_io_pkg.sv
`timescale 1ps/1ps
// sc_io_pkg
// Shared constants for the sc_computer board front end.
//  - PORT_W        : width of the CPU I/O ports (32)
//  - SEG_CODE_*    : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//  - seg_code_low  : digit (0-9) to active-low code; any other value gives a dash
package sc_io_pkg;

  localparam int PORT_W = 32;

  localparam logic [6:0] SEG_CODE_0 = 7'h40;
  localparam logic [6:0] SEG_CODE_1 = 7'h79;
  localparam logic [6:0] SEG_CODE_2 = 7'h24;
  localparam logic [6:0] SEG_CODE_3 = 7'h30;
  localparam logic [6:0] SEG_CODE_4 = 7'h19;
  localparam logic [6:0] SEG_CODE_5 = 7'h12;
  localparam logic [6:0] SEG_CODE_6 = 7'h02;
  localparam logic [6:0] SEG_CODE_7 = 7'h78;
  localparam logic [6:0] SEG_CODE_8 = 7'h00;
  localparam logic [6:0] SEG_CODE_9 = 7'h10;
  localparam logic [6:0] SEG_DASH   = 7'h3F;

  // Non-decimal nibbles cannot come out of the digit split, but map them
  // to a dash so the decoder is fully specified.
  function automatic logic [6:0] seg_code_low(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_CODE_0;
      4'd1:    code = SEG_CODE_1;
      4'd2:    code = SEG_CODE_2;
      4'd3:    code = SEG_CODE_3;
      4'd4:    code = SEG_CODE_4;
      4'd5:    code = SEG_CODE_5;
      4'd6:    code = SEG_CODE_6;
      4'd7:    code = SEG_CODE_7;
      4'd8:    code = SEG_CODE_8;
      4'd9:    code = SEG_CODE_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
`timescale 1ps/1ps
// seg7_dec
// One decimal 7-segment digit decoder.
// Ports:
//  digit  in   4  decimal digit 0-9
//  dash   in   1  1: show a dash instead of the digit
//  seg    out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
module seg7_dec
  import sc_io_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] code_low;

  always_comb begin
    code_low = seg_code_low(digit);
    if (dash) begin
      code_low = SEG_DASH;
    end
  end

  // The code table is stored active-low; boards that light on 1 get the complement.
  assign seg = SEG_ACTIVE_LOW ? code_low : ~code_low;

endmodule

// File: rtl/sc_io_frontend.sv
`timescale 1ps/1ps
// sc_io_frontend
// Board-side front end for sc_computer: clock division, switch packing and
// decimal 7-segment display of the three CPU output ports. No CPU logic.
// Ports:
//  clock_50M   in   1   board clock, the only clock in this block
//  resetn      in   1   asynchronous active-low reset (divider only)
//  sw          in   10  slide switches
//  out_port0   in   32  shown on hex5 (tens) / hex4 (ones)
//  out_port1   in   32  shown on hex3 (tens) / hex2 (ones)
//  out_port2   in   32  shown on hex1 (tens) / hex0 (ones)
//  clock       out  1   CPU clock, clock_50M / 4
//  mem_clock   out  1   memory clock, clock_50M / 2
//  in_port0    out  32  zero-extended sw[4:0]
//  in_port1    out  32  zero-extended sw[9:5]
//  hex0..hex5  out  7   segments {g,f,e,d,c,b,a}
module sc_io_frontend
  import sc_io_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_OVER_99  = 1'b1
) (
  input  logic              clock_50M,
  input  logic              resetn,
  input  logic [9:0]        sw,
  input  logic [PORT_W-1:0] out_port0,
  input  logic [PORT_W-1:0] out_port1,
  input  logic [PORT_W-1:0] out_port2,
  output logic              clock,
  output logic              mem_clock,
  output logic [PORT_W-1:0] in_port0,
  output logic [PORT_W-1:0] in_port1,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5
);

  logic [1:0] cnt;

  // Both derived clocks come straight from flop outputs so they cannot glitch;
  // clock rises on the same board edge that mem_clock falls.
  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) begin
      cnt <= 2'b00;
    end else begin
      cnt <= cnt + 2'd1;
    end
  end

  assign mem_clock = cnt[0];
  assign clock     = cnt[1];

  assign in_port0 = {{(PORT_W-5){1'b0}}, sw[4:0]};
  assign in_port1 = {{(PORT_W-5){1'b0}}, sw[9:5]};

  logic [PORT_W-1:0] port_val [3];
  logic [6:0]        seg_tens [3];
  logic [6:0]        seg_ones [3];

  assign port_val[0] = out_port0;
  assign port_val[1] = out_port1;
  assign port_val[2] = out_port2;

  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_port
      logic [3:0] tens;
      logic [3:0] ones;
      logic       dash;

      // The full 32-bit value is compared, so large values never alias
      // into a valid-looking two-digit number when blanking is enabled.
      always_comb begin
        ones = 4'(port_val[i] % PORT_W'(10));
        tens = 4'((port_val[i] / PORT_W'(10)) % PORT_W'(10));
        dash = BLANK_OVER_99 && (port_val[i] > PORT_W'(99));
      end

      seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_tens (
        .digit (tens),
        .dash  (dash),
        .seg   (seg_tens[i])
      );

      seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_ones (
        .digit (ones),
        .dash  (dash),
        .seg   (seg_ones[i])
      );
    end
  endgenerate

  assign hex5 = seg_tens[0];
  assign hex4 = seg_ones[0];
  assign hex3 = seg_tens[1];
  assign hex2 = seg_ones[1];
  assign hex1 = seg_tens[2];
  assign hex0 = seg_ones[2];

endmodule

// File: tb/tb_sc_io_frontend.sv
`timescale 1ps/1ps
// tb_sc_io_frontend
// Self-checking bench for sc_io_frontend. Two instances share all inputs:
// the default build (active-low, blanking above 99) and an inverted build
// (active-high, value mod 100). Expected values come from decimal arithmetic
// on the port values and an edge count since reset.
module tb_sc_io_frontend;

  logic        clock_50M = 1'b0;
  logic        resetn    = 1'b0;
  logic [9:0]  sw        = '0;
  logic [31:0] out_port0 = '0;
  logic [31:0] out_port1 = '0;
  logic [31:0] out_port2 = '0;

  logic        clock, mem_clock;
  logic [31:0] in_port0, in_port1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  logic        inv_clock, inv_mem_clock;
  logic [31:0] inv_in_port0, inv_in_port1;
  logic [6:0]  inv_hex0, inv_hex1, inv_hex2, inv_hex3, inv_hex4, inv_hex5;

  int total = 0;
  int bad   = 0;
  int ticks = 0;

  logic [6:0] low_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #2 clock_50M = ~clock_50M;

  sc_io_frontend dut (
    .clock_50M (clock_50M), .resetn (resetn), .sw (sw),
    .out_port0 (out_port0), .out_port1 (out_port1), .out_port2 (out_port2),
    .clock (clock), .mem_clock (mem_clock),
    .in_port0 (in_port0), .in_port1 (in_port1),
    .hex0 (hex0), .hex1 (hex1), .hex2 (hex2),
    .hex3 (hex3), .hex4 (hex4), .hex5 (hex5)
  );

  sc_io_frontend #(.SEG_ACTIVE_LOW(1'b0), .BLANK_OVER_99(1'b0)) dut_inv (
    .clock_50M (clock_50M), .resetn (resetn), .sw (sw),
    .out_port0 (out_port0), .out_port1 (out_port1), .out_port2 (out_port2),
    .clock (inv_clock), .mem_clock (inv_mem_clock),
    .in_port0 (inv_in_port0), .in_port1 (inv_in_port1),
    .hex0 (inv_hex0), .hex1 (inv_hex1), .hex2 (inv_hex2),
    .hex3 (inv_hex3), .hex4 (inv_hex4), .hex5 (inv_hex5)
  );

  // Expected segment pattern for one digit of a displayed value.
  function automatic logic [6:0] seg_of(input logic [31:0] v, input bit tens_digit,
                                        input bit act_low, input bit blank);
    logic [31:0] d;
    logic [6:0]  code;
    if (blank && v > 32'd99) begin
      code = 7'h3F;
    end else begin
      d    = tens_digit ? (v / 32'd10) % 32'd10 : v % 32'd10;
      code = low_codes[int'(d)];
    end
    return act_low ? code : ~code;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] s, input logic [31:0] p0,
                               input logic [31:0] p1, input logic [31:0] p2);
    sw        = s;
    out_port0 = p0;
    out_port1 = p1;
    out_port2 = p2;
    #1;
  endtask

  // Divider model: after k board edges since release, mem_clock = bit 0 of k
  // and clock = bit 1 of k.
  task automatic checkDivider(input string tag);
    checkOutput({tag, " mem_clock"},     {31'b0, mem_clock},     ticks % 2);
    checkOutput({tag, " clock"},         {31'b0, clock},         (ticks / 2) % 2);
    checkOutput({tag, " inv_mem_clock"}, {31'b0, inv_mem_clock}, ticks % 2);
    checkOutput({tag, " inv_clock"},     {31'b0, inv_clock},     (ticks / 2) % 2);
  endtask

  task automatic checkPorts(input string tag);
    logic [31:0] swv;
    swv = {22'b0, sw};
    checkOutput({tag, " in_port0"}, in_port0, swv % 32);
    checkOutput({tag, " in_port1"}, in_port1, swv / 32);
    checkOutput({tag, " inv_in_port0"}, inv_in_port0, swv % 32);
    checkOutput({tag, " inv_in_port1"}, inv_in_port1, swv / 32);
    checkOutput({tag, " hex5"}, hex5, seg_of(out_port0, 1'b1, 1'b1, 1'b1));
    checkOutput({tag, " hex4"}, hex4, seg_of(out_port0, 1'b0, 1'b1, 1'b1));
    checkOutput({tag, " hex3"}, hex3, seg_of(out_port1, 1'b1, 1'b1, 1'b1));
    checkOutput({tag, " hex2"}, hex2, seg_of(out_port1, 1'b0, 1'b1, 1'b1));
    checkOutput({tag, " hex1"}, hex1, seg_of(out_port2, 1'b1, 1'b1, 1'b1));
    checkOutput({tag, " hex0"}, hex0, seg_of(out_port2, 1'b0, 1'b1, 1'b1));
    checkOutput({tag, " inv_hex5"}, inv_hex5, seg_of(out_port0, 1'b1, 1'b0, 1'b0));
    checkOutput({tag, " inv_hex4"}, inv_hex4, seg_of(out_port0, 1'b0, 1'b0, 1'b0));
    checkOutput({tag, " inv_hex3"}, inv_hex3, seg_of(out_port1, 1'b1, 1'b0, 1'b0));
    checkOutput({tag, " inv_hex2"}, inv_hex2, seg_of(out_port1, 1'b0, 1'b0, 1'b0));
    checkOutput({tag, " inv_hex1"}, inv_hex1, seg_of(out_port2, 1'b1, 1'b0, 1'b0));
    checkOutput({tag, " inv_hex0"}, inv_hex0, seg_of(out_port2, 1'b0, 1'b0, 1'b0));
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom_range(0, 9);
      1:       v = $urandom_range(10, 99);
      2:       v = $urandom_range(100, 1000);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    // Divider held in reset
    #1;
    ticks = 0;
    checkDivider("in_reset");

    // Release at 5 ps; first posedge after release is at 6 ps
    #4;
    resetn = 1'b1;
    repeat (12) begin
      @(posedge clock_50M);
      #1;
      ticks++;
      checkDivider("run");
    end

    // Move to a point where the CPU clock is high, then reset mid-cycle
    repeat (4) begin
      if ((ticks / 2) % 2 != 1) begin
        @(posedge clock_50M);
        #1;
        ticks++;
      end
    end
    checkDivider("pre_pulse");
    checkOutput("pre_pulse clock_high", {31'b0, clock}, 32'd1);
    resetn = 1'b0;
    #1;
    ticks = 0;
    checkDivider("async_reset");
    #1;
    resetn = 1'b1;
    repeat (8) begin
      @(posedge clock_50M);
      #1;
      ticks++;
      checkDivider("restart");
    end

    // Directed switch and display cases
    applyStimulus(10'b01000_00101, 32'd5, 32'd8, 32'd13);
    checkPorts("dir_a");
    checkOutput("dir_a in0_lit", in_port0, 32'd5);
    checkOutput("dir_a in1_lit", in_port1, 32'd8);
    checkOutput("dir_a hex5_lit", {25'b0, hex5}, 32'h40);
    checkOutput("dir_a hex4_lit", {25'b0, hex4}, 32'h12);
    checkOutput("dir_a hex2_lit", {25'b0, hex2}, 32'h00);
    checkOutput("dir_a hex1_lit", {25'b0, hex1}, 32'h79);
    checkOutput("dir_a hex0_lit", {25'b0, hex0}, 32'h30);

    applyStimulus(~10'b01000_00101, 32'd0, 32'd62, 32'd99);
    checkPorts("dir_b");
    checkOutput("dir_b in0_lit", in_port0, 32'd26);
    checkOutput("dir_b in1_lit", in_port1, 32'd23);
    checkOutput("dir_b hex3_lit", {25'b0, hex3}, 32'h02);
    checkOutput("dir_b hex2_lit", {25'b0, hex2}, 32'h24);
    checkOutput("dir_b hex1_lit", {25'b0, hex1}, 32'h10);
    checkOutput("dir_b hex0_lit", {25'b0, hex0}, 32'h10);

    applyStimulus(10'h3FF, 32'd100, 32'hFFFF_FFFF, 32'd9);
    checkPorts("dir_c");
    checkOutput("dir_c hex5_lit", {25'b0, hex5}, 32'h3F);
    checkOutput("dir_c hex2_lit", {25'b0, hex2}, 32'h3F);
    checkOutput("dir_c hex1_lit", {25'b0, hex1}, 32'h40);

    // Randomized sweep
    for (int n = 0; n < 30; n++) begin
      applyStimulus(10'($urandom_range(0, 1023)), rand_val(), rand_val(), rand_val());
      checkPorts("rand");
    end

    // Display and switch paths ignore reset
    resetn = 1'b0;
    applyStimulus(10'($urandom_range(0, 1023)), 32'd0, 32'd47, 32'd123);
    ticks = 0;
    checkDivider("late_reset");
    checkPorts("late_reset");
    checkOutput("late_reset hex5_lit", {25'b0, hex5}, 32'h40);
    checkOutput("late_reset hex4_lit", {25'b0, hex4}, 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
